// File: rtl/serial_feeder_if.sv
// Handshake and serial-stream bundle between a word source, serial_feeder and the shift stage.
// Optional parity_o is present only when SERIAL_FEEDER_PARITY_EN is defined.
interface serial_feeder_if #(
   parameter int unsigned WIDTH = 4
);
   logic             valid_i;
   logic             ready_o;
   logic [WIDTH-1:0] word_i;
   logic [1:0]       funct_o;
   logic             serial_o;
   logic             busy_o;
   logic             done_o;
`ifdef SERIAL_FEEDER_PARITY_EN
   logic             parity_o;
`endif

   // Word source side.
   modport master (
      output valid_i,
      output word_i,
      input  ready_o,
      input  funct_o,
      input  serial_o,
      input  busy_o,
`ifdef SERIAL_FEEDER_PARITY_EN
      input  parity_o,
`endif
      input  done_o
   );

   // Feeder side.
   modport slave (
      input  valid_i,
      input  word_i,
      output ready_o,
      output funct_o,
      output serial_o,
      output busy_o,
`ifdef SERIAL_FEEDER_PARITY_EN
      output parity_o,
`endif
      output done_o
   );
endinterface

// File: rtl/serial_feeder.sv
// Serializes accepted parallel words into a downstream shift register, then idles GAP cycles.
// Define SERIAL_FEEDER_PARITY_EN to add a registered even-parity output for each completed word.
module serial_feeder #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned GAP       = 1,
   parameter int unsigned MSB_FIRST = 1
) (
   input logic          clk,
   input logic          rst,
   serial_feeder_if.slave bus
);
   localparam logic [1:0] FunctNa    = 2'b00;
   localparam logic [1:0] FunctLeft  = 2'b01;
   localparam logic [1:0] FunctRight = 2'b10;

   localparam int unsigned CntW    = $clog2(WIDTH);
   localparam int unsigned GapW    = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
   localparam logic [GapW-1:0] GapLast = GapW'((GAP > 0) ? GAP - 1 : 0);

   typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] buf_q, buf_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [GapW-1:0]  gap_q, gap_d;
   logic             done_q, done_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         buf_q   <= '0;
         cnt_q   <= '0;
         gap_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            // ready_o is high throughout IDLE, so valid_i alone means accept.
            if (bus.valid_i) begin
               buf_d   = bus.word_i;
               cnt_d   = '0;
               state_d = StShift;
            end
         end
         StShift: begin
            if (MSB_FIRST != 0) begin
               buf_d = {buf_q[WIDTH-2:0], 1'b0};
            end else begin
               buf_d = {1'b0, buf_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntLast) begin
               cnt_d   = '0;
               gap_d   = '0;
               done_d  = 1'b1;
               state_d = (GAP > 0) ? StGap : StIdle;
            end
         end
         StGap: begin
            gap_d = gap_q + GapW'(1);
            if (gap_q == GapLast) begin
               gap_d   = '0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.ready_o  = 1'b0;
      bus.funct_o  = FunctNa;
      bus.serial_o = 1'b0;
      bus.busy_o   = 1'b0;
      unique case (state_q)
         StIdle: bus.ready_o = 1'b1;
         StShift: begin
            bus.busy_o = 1'b1;
            if (MSB_FIRST != 0) begin
               bus.funct_o  = FunctLeft;
               bus.serial_o = buf_q[WIDTH-1];
            end else begin
               bus.funct_o  = FunctRight;
               bus.serial_o = buf_q[0];
            end
         end
         StGap: bus.busy_o = 1'b1;
         default: bus.busy_o = 1'b0;
      endcase
   end

   assign bus.done_o = done_q;

`ifdef SERIAL_FEEDER_PARITY_EN
   // Parity is captured at accept but published only with done, so it holds for a whole word period.
   logic par_pend_q;
   logic parity_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         par_pend_q <= 1'b0;
         parity_q   <= 1'b0;
      end else begin
         if ((state_q == StIdle) && bus.valid_i) begin
            par_pend_q <= ^bus.word_i;
         end
         if (done_d) begin
            parity_q <= par_pend_q;
         end
      end
   end

   assign bus.parity_o = parity_q;
`endif
endmodule

// File: tb/tb_serial_feeder.sv
// Directed bench for serial_feeder: four configurations driven in lockstep, with bench-side
// downstream shift register models.
module tb_serial_feeder;
   localparam logic [1:0] FNA    = 2'b00;
   localparam logic [1:0] FLEFT  = 2'b01;
   localparam logic [1:0] FRIGHT = 2'b10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid = 1'b0;
   logic [3:0] word = 4'b0000;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   serial_feeder_if #(.WIDTH(4)) if0 ();
   serial_feeder_if #(.WIDTH(4)) if1 ();
   serial_feeder_if #(.WIDTH(4)) if2 ();
   serial_feeder_if #(.WIDTH(4)) if3 ();

   assign if0.valid_i = valid;
   assign if0.word_i  = word;
   assign if1.valid_i = valid;
   assign if1.word_i  = word;
   assign if2.valid_i = valid;
   assign if2.word_i  = word;
   assign if3.valid_i = valid;
   assign if3.word_i  = word;

   serial_feeder #(.WIDTH(4), .GAP(1), .MSB_FIRST(1)) u0 (.clk(clk), .rst(rst), .bus(if0));
   serial_feeder #(.WIDTH(4), .GAP(1), .MSB_FIRST(0)) u1 (.clk(clk), .rst(rst), .bus(if1));
   serial_feeder #(.WIDTH(4), .GAP(2), .MSB_FIRST(1)) u2 (.clk(clk), .rst(rst), .bus(if2));
   serial_feeder #(.WIDTH(4), .GAP(0), .MSB_FIRST(1)) u3 (.clk(clk), .rst(rst), .bus(if3));

   // Downstream shift_register behaviour: LEFT fills from bit 0, RIGHT fills from bit 3.
   function automatic logic [3:0] ds_next(input logic [3:0] ds, input logic [1:0] f,
                                          input logic s);
      case (f)
         FLEFT:   return {ds[2:0], s};
         FRIGHT:  return {s, ds[3:1]};
         default: return ds;
      endcase
   endfunction

   logic [3:0] ds0, ds1, ds2, ds3;
   always_ff @(posedge clk) begin
      if (rst) begin
         ds0 <= '0;
         ds1 <= '0;
         ds2 <= '0;
         ds3 <= '0;
      end else begin
         ds0 <= ds_next(ds0, if0.funct_o, if0.serial_o);
         ds1 <= ds_next(ds1, if1.funct_o, if1.serial_o);
         ds2 <= ds_next(ds2, if2.funct_o, if2.serial_o);
         ds3 <= ds_next(ds3, if3.funct_o, if3.serial_o);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // msb_seq / lsb_seq: emitted serial bits, first bit in position [3].
   typedef struct {
      logic [3:0] word;
      logic [3:0] msb_seq;
      logic [3:0] lsb_seq;
      logic       par;
   } vec_t;

   vec_t vecs[6];

   // GAP=2 held-valid sequence, cycles k+1..k+7 after the first accept.
   logic [6:0] g_ready  = 7'b0000001;
   logic [6:0] g_busy   = 7'b1111110;
   logic [6:0] g_done   = 7'b0000100;
   logic [6:0] g_serial = 7'b1011000;
   logic [6:0] g_left   = 7'b1111000;
   logic [3:0] w2_seq   = 4'b0110;

   initial begin
      int dcnt;
      vecs[0] = '{word: 4'b1011, msb_seq: 4'b1011, lsb_seq: 4'b1101, par: 1'b1};
      vecs[1] = '{word: 4'b0110, msb_seq: 4'b0110, lsb_seq: 4'b0110, par: 1'b0};
      vecs[2] = '{word: 4'b1000, msb_seq: 4'b1000, lsb_seq: 4'b0001, par: 1'b1};
      vecs[3] = '{word: 4'b0001, msb_seq: 4'b0001, lsb_seq: 4'b1000, par: 1'b1};
      vecs[4] = '{word: 4'b1111, msb_seq: 4'b1111, lsb_seq: 4'b1111, par: 1'b0};
      vecs[5] = '{word: 4'b0000, msb_seq: 4'b0000, lsb_seq: 4'b0000, par: 1'b0};

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst ready", if0.ready_o, 1);
      check("rst funct", if0.funct_o, FNA);
      check("rst serial", if0.serial_o, 0);
      check("rst busy", if0.busy_o, 0);
      check("rst done", if0.done_o, 0);
      check("rst u1 ready", if1.ready_o, 1);
      check("rst u2 ready", if2.ready_o, 1);
      check("rst u3 busy", if3.busy_o, 0);
`ifdef SERIAL_FEEDER_PARITY_EN
      check("rst parity", if0.parity_o, 0);
`endif
      rst = 1'b0;

      // Table-driven single words: u0 MSB-first/LEFT, u1 LSB-first/RIGHT.
      for (int v = 0; v < 6; v++) begin
         valid = 1'b1;
         word  = vecs[v].word;
         @(negedge clk);
         valid = 1'b0;
         word  = ~vecs[v].word;
         for (int i = 0; i < 4; i++) begin
            check($sformatf("v%0d b%0d u0 funct", v, i), if0.funct_o, FLEFT);
            check($sformatf("v%0d b%0d u1 funct", v, i), if1.funct_o, FRIGHT);
            check($sformatf("v%0d b%0d u0 serial", v, i), if0.serial_o, vecs[v].msb_seq[3-i]);
            check($sformatf("v%0d b%0d u1 serial", v, i), if1.serial_o, vecs[v].lsb_seq[3-i]);
            check($sformatf("v%0d b%0d u0 ready", v, i), if0.ready_o, 0);
            check($sformatf("v%0d b%0d u0 done", v, i), if0.done_o, 0);
            @(negedge clk);
         end
         check($sformatf("v%0d u0 done", v), if0.done_o, 1);
         check($sformatf("v%0d u1 done", v), if1.done_o, 1);
         check($sformatf("v%0d u0 ds", v), ds0, vecs[v].word);
         check($sformatf("v%0d u1 ds", v), ds1, vecs[v].word);
         check($sformatf("v%0d u0 gap funct", v), if0.funct_o, FNA);
         check($sformatf("v%0d u0 gap busy", v), if0.busy_o, 1);
         check($sformatf("v%0d u0 gap ready", v), if0.ready_o, 0);
`ifdef SERIAL_FEEDER_PARITY_EN
         check($sformatf("v%0d parity", v), if0.parity_o, vecs[v].par);
`endif
         @(negedge clk);
         check($sformatf("v%0d u0 done low", v), if0.done_o, 0);
         check($sformatf("v%0d u0 idle ready", v), if0.ready_o, 1);
         check($sformatf("v%0d u0 idle busy", v), if0.busy_o, 0);
`ifdef SERIAL_FEEDER_PARITY_EN
         check($sformatf("v%0d parity hold", v), if0.parity_o, vecs[v].par);
`endif
         @(negedge clk);
      end

      // Held valid: u2 (GAP=2) period 7, u3 (GAP=0) period 5.
      valid = 1'b1;
      word  = 4'b1011;
      @(negedge clk);
      for (int c = 1; c <= 7; c++) begin
         check($sformatf("g2 c%0d ready", c), if2.ready_o, g_ready[7-c]);
         check($sformatf("g2 c%0d busy", c), if2.busy_o, g_busy[7-c]);
         check($sformatf("g2 c%0d done", c), if2.done_o, g_done[7-c]);
         check($sformatf("g2 c%0d serial", c), if2.serial_o, g_serial[7-c]);
         check($sformatf("g2 c%0d funct", c), if2.funct_o, g_left[7-c] ? FLEFT : FNA);
         if (c == 5) begin
            check("g0 done", if3.done_o, 1);
            check("g0 ready", if3.ready_o, 1);
            check("g0 busy", if3.busy_o, 0);
            check("g0 ds", ds3, 4'b1011);
            check("g2 ds first", ds2, 4'b1011);
         end
         if (c == 6) begin
            check("g0 second funct", if3.funct_o, FLEFT);
            check("g0 second serial", if3.serial_o, 0);
         end
         if (c == 1) word = 4'b0110;
         @(negedge clk);
      end
      for (int i = 0; i < 4; i++) begin
         check($sformatf("g2 w2 b%0d funct", i), if2.funct_o, FLEFT);
         check($sformatf("g2 w2 b%0d serial", i), if2.serial_o, w2_seq[3-i]);
         valid = 1'b0;
         @(negedge clk);
      end
      check("g2 w2 done", if2.done_o, 1);
      check("g2 w2 ds", ds2, 4'b0110);
`ifdef SERIAL_FEEDER_PARITY_EN
      check("g2 w2 parity", if2.parity_o, 0);
`endif

      // Reset in the second SHIFT cycle aborts the word.
      repeat (12) @(negedge clk);
      valid = 1'b1;
      word  = 4'b1011;
      @(negedge clk);
      valid = 1'b0;
      @(negedge clk);
      check("abort pre busy", if0.busy_o, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort ready", if0.ready_o, 1);
      check("abort funct", if0.funct_o, FNA);
      check("abort busy", if0.busy_o, 0);
      check("abort serial", if0.serial_o, 0);
      check("abort u2 ready", if2.ready_o, 1);
      dcnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (if0.done_o || if1.done_o || if2.done_o || if3.done_o) dcnt++;
         @(negedge clk);
      end
      check("abort no done", dcnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
